// File: rtl/uart_pkg.sv
// Shared definitions for the uart TX queue: uart and queue register offsets,
// STAT bit positions and the one-hot drain FSM encoding.
package uart_pkg;

  localparam logic [7:0] UART_CTRL   = 8'h00;
  localparam logic [7:0] UART_STATUS = 8'h04;
  localparam logic [7:0] UART_BAUD   = 8'h08;
  localparam logic [7:0] UART_TXDATA = 8'h0C;
  localparam logic [7:0] UART_RXDATA = 8'h10;

  localparam logic [7:0] Q_CTRL   = 8'h00;
  localparam logic [7:0] Q_STAT   = 8'h04;
  localparam logic [7:0] Q_TXD    = 8'h08;
  localparam logic [7:0] Q_THRESH = 8'h0C;

  localparam int unsigned STAT_EMPTY = 8;
  localparam int unsigned STAT_FULL  = 9;
  localparam int unsigned STAT_OVF   = 10;
  localparam int unsigned STAT_BUSY  = 11;

  typedef enum logic [5:0] {
    S_OFF   = 6'b000001,
    S_INIT  = 6'b000010,
    S_IDLE  = 6'b000100,
    S_POLL  = 6'b001000,
    S_WRITE = 6'b010000,
    S_WAIT  = 6'b100000
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == S_INIT) || (s == S_POLL) || (s == S_WRITE) || (s == S_WAIT);
  endfunction

endpackage

// File: rtl/uart_tx_queue_if.sv
// Bundle of the CPU register bus and the uart register port used by uart_tx_queue.
interface uart_tx_queue_if;
  // we_i is a single-cycle write strobe that is always accepted (no ready);
  // reads are combinational from addr_i. uart_we_o is likewise a one-cycle
  // strobe the uart always accepts; uart_data_i answers uart_addr_o in-cycle.
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        uart_we_o;
  logic [31:0] uart_addr_o;
  logic [31:0] uart_data_o;
  logic [31:0] uart_data_i;

  modport master (
    output we_i, addr_i, data_i, uart_data_i,
    input  data_o, uart_we_o, uart_addr_o, uart_data_o
  );

  modport slave (
    input  we_i, addr_i, data_i, uart_data_i,
    output data_o, uart_we_o, uart_addr_o, uart_data_o
  );
endinterface

// File: rtl/sync_fifo.sv
// Byte FIFO with push/pop/flush, level counter and combinational head byte.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [7:0]    wdata,
  output logic [7:0]    head,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  // A push into a full FIFO is dropped even when a pop frees a slot that cycle.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// CPU-facing byte queue that drains into the uart TXDATA register.
// Optional THRESH register and irq_o are built when UART_TXQ_IRQ_EN is defined.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_queue_if.slave   bus,
  output state_t           dbg_state
`ifdef UART_TXQ_IRQ_EN
  ,
  output logic             irq_o
`endif
);

  logic [7:0]  reg_addr;
  logic        wr_ctrl;
  logic        wr_stat;
  logic        wr_txd;
  logic        flush;
  logic        pop;
  logic        ctrl_en;
  logic        overflow;
  logic [7:0]  head;
  logic [AW:0] level;
  logic        empty;
  logic        full;
  logic [31:0] rdata;
  state_t      state;
  state_t      nxt;
  logic        uart_we_q;
  logic [31:0] uart_addr_q;
  logic [31:0] uart_data_q;
  logic        unused_bits;

  assign reg_addr = bus.addr_i[7:0];
  assign wr_ctrl  = bus.we_i & (reg_addr == Q_CTRL);
  assign wr_stat  = bus.we_i & (reg_addr == Q_STAT);
  assign wr_txd   = bus.we_i & (reg_addr == Q_TXD);
  assign flush    = wr_ctrl & bus.data_i[1];
  assign pop      = (state == S_WRITE);

  assign unused_bits = ^{bus.addr_i[31:8], bus.data_i[31:11], bus.data_i[9:8],
                         bus.uart_data_i[31:1]};

  sync_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_txd),
    .pop   (pop),
    .flush (flush),
    .wdata (bus.data_i[7:0]),
    .head  (head),
    .level (level),
    .empty (empty),
    .full  (full)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_en  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_en <= bus.data_i[0];
      if (wr_txd && full)                     overflow <= 1'b1;
      else if (wr_stat && bus.data_i[STAT_OVF]) overflow <= 1'b0;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_OFF:   if (ctrl_en) nxt = S_INIT;
      S_INIT:  nxt = S_IDLE;
      S_IDLE:  if (!ctrl_en) nxt = S_OFF;
               else if (!empty) nxt = S_POLL;
      S_POLL:  if (!ctrl_en) nxt = S_OFF;
               else if (!bus.uart_data_i[0]) nxt = S_WRITE;
      S_WRITE: nxt = S_WAIT;
      S_WAIT:  nxt = S_IDLE;
      default: nxt = S_OFF;
    endcase
  end

  // uart port outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_OFF;
      uart_we_q   <= 1'b0;
      uart_addr_q <= {24'h0, UART_STATUS};
      uart_data_q <= '0;
    end else begin
      state       <= nxt;
      uart_we_q   <= (nxt == S_INIT) || (nxt == S_WRITE);
      uart_addr_q <= (nxt == S_INIT)  ? {24'h0, UART_CTRL} :
                     (nxt == S_WRITE) ? {24'h0, UART_TXDATA} : {24'h0, UART_STATUS};
      uart_data_q <= (nxt == S_INIT)  ? 32'h1 :
                     (nxt == S_WRITE) ? {24'h0, head} : 32'h0;
    end
  end

  // The strobe is masked by reset so an interrupted write never reaches the uart.
  assign bus.uart_we_o   = uart_we_q & rst;
  assign bus.uart_addr_o = uart_addr_q;
  assign bus.uart_data_o = uart_data_q;
  assign dbg_state       = state;

`ifdef UART_TXQ_IRQ_EN
  logic [AW:0] thresh;
  logic        irq_q;
  logic        wr_thresh;

  assign wr_thresh = bus.we_i & (reg_addr == Q_THRESH);

  always_ff @(posedge clk) begin
    if (!rst) begin
      thresh <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_thresh) thresh <= bus.data_i[AW:0];
      irq_q <= ctrl_en & (level <= thresh);
    end
  end

  assign irq_o = irq_q;
`endif

  always_comb begin
    rdata = '0;
    if (rst) begin
      case (reg_addr)
        Q_CTRL: rdata[0] = ctrl_en;
        Q_STAT: begin
          rdata[AW:0]       = level;
          rdata[STAT_EMPTY] = empty;
          rdata[STAT_FULL]  = full;
          rdata[STAT_OVF]   = overflow;
          rdata[STAT_BUSY]  = is_busy(state);
        end
`ifdef UART_TXQ_IRQ_EN
        Q_THRESH: rdata[AW:0] = thresh;
`endif
        default: rdata = '0;
      endcase
    end
  end

  assign bus.data_o = rdata;

endmodule
